// File: rtl/vocoder_pkg.sv
// rtl/vocoder_pkg.sv - shared types and default constants for the vocoder front end
package vocoder_pkg;
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} sched_state_t;

    localparam int NUM_BANDS_DEF = 15;
    localparam int DW_DEF        = 16;
    localparam int SAMPLE_PERIOD = 100;
endpackage

// File: rtl/next_stream_pick.sv
// rtl/next_stream_pick.sv - priority encoder returning the lowest enabled stream after cur
module next_stream_pick #(
    parameter int N  = 2,
    parameter int IW = 1
) (
    input  logic [N-1:0]  mask,
    input  logic [IW-1:0] cur,
    input  logic          from_start,
    output logic [IW-1:0] nxt,
    output logic          none
);
    // Scan downward so the lowest qualifying index is the last one written
    always_comb begin
        nxt  = '0;
        none = 1'b1;
        for (int i = N - 1; i >= 0; i--) begin
            if (mask[i] && (from_start || i > int'(cur))) begin
                nxt  = IW'(i);
                none = 1'b0;
            end
        end
    end
endmodule

// File: rtl/filterbank_scheduler.sv
// rtl/filterbank_scheduler.sv - time-multiplexes one mel filterbank across several PCM streams
module filterbank_scheduler
    import vocoder_pkg::*;
#(
    parameter int NUM_STREAMS = 2,
    parameter int NUM_BANDS   = NUM_BANDS_DEF,
    parameter int DW          = DW_DEF,
    parameter int TIMEOUT     = 95
) (
    input  logic                                         clk,
    input  logic                                         rst,
    input  logic                                         sample_valid,
    input  logic [NUM_STREAMS-1:0][DW-1:0]               sample_in,
    input  logic [NUM_STREAMS-1:0]                       stream_en,
    input  logic                                         err_clr,
    output logic                                         fb_pcm_valid,
    output logic [DW-1:0]                                fb_din,
    input  logic [NUM_BANDS-1:0][DW-1:0]                 fb_dout,
    input  logic                                         fb_valid,
    output logic [NUM_STREAMS-1:0][NUM_BANDS-1:0][DW-1:0] band_out,
    output logic                                         frame_valid,
    output logic                                         busy,
    output logic                                         overrun,
    output logic                                         timeout_err
);
    localparam int IW = (NUM_STREAMS > 1) ? $clog2(NUM_STREAMS) : 1;
    localparam int CW = $clog2(TIMEOUT);

    sched_state_t                  state;
    logic [NUM_STREAMS-1:0][DW-1:0] buf_q;
    logic [NUM_STREAMS-1:0]        mask_q;
    logic [IW-1:0]                 idx;
    logic [CW-1:0]                 cnt;

    logic [IW-1:0] first_idx, nxt_idx;
    logic          first_none, nxt_none;

    next_stream_pick #(.N(NUM_STREAMS), .IW(IW)) u_pick_first (
        .mask(stream_en), .cur('0), .from_start(1'b1),
        .nxt(first_idx), .none(first_none)
    );

    next_stream_pick #(.N(NUM_STREAMS), .IW(IW)) u_pick_next (
        .mask(mask_q), .cur(idx), .from_start(1'b0),
        .nxt(nxt_idx), .none(nxt_none)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            buf_q        <= '0;
            mask_q       <= '0;
            idx          <= '0;
            cnt          <= '0;
            fb_pcm_valid <= 1'b0;
            fb_din       <= '0;
            band_out     <= '0;
            frame_valid  <= 1'b0;
            busy         <= 1'b0;
            overrun      <= 1'b0;
            timeout_err  <= 1'b0;
        end else begin
            fb_pcm_valid <= 1'b0;
            frame_valid  <= 1'b0;

            // Sticky flags: a new error in the same cycle as err_clr wins
            if (sample_valid && state != IDLE) overrun <= 1'b1;
            else if (err_clr)                  overrun <= 1'b0;
            if (err_clr) timeout_err <= 1'b0;

            case (state)
                IDLE: begin
                    if (sample_valid) begin
                        buf_q  <= sample_in;
                        mask_q <= stream_en;
                        busy   <= 1'b1;
                        if (first_none) begin
                            idx         <= '0;
                            state       <= DONE;
                            frame_valid <= 1'b1;
                        end else begin
                            idx          <= first_idx;
                            state        <= ISSUE;
                            fb_pcm_valid <= 1'b1;
                            fb_din       <= sample_in[first_idx];
                        end
                    end
                end
                ISSUE: begin
                    cnt   <= '0;
                    state <= WAIT;
                end
                WAIT: begin
                    cnt <= cnt + 1'b1;
                    if (fb_valid || cnt == CW'(TIMEOUT - 1)) begin
                        if (fb_valid) band_out[idx] <= fb_dout;
                        else          timeout_err   <= 1'b1;
                        if (nxt_none) begin
                            state       <= DONE;
                            frame_valid <= 1'b1;
                            fb_din      <= '0;
                        end else begin
                            idx          <= nxt_idx;
                            state        <= ISSUE;
                            fb_pcm_valid <= 1'b1;
                            fb_din       <= buf_q[nxt_idx];
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_filterbank_scheduler.sv
// tb/tb_filterbank_scheduler.sv - scoreboard bench for filterbank_scheduler with a fixed-latency filterbank model
module tb_filterbank_scheduler;
    localparam int N = 2, B = 15, W = 16, TO = 95;

    typedef logic [N-1:0][B-1:0][W-1:0] bands_t;
    typedef logic [B-1:0][W-1:0]        vec_t;
    typedef logic [N-1:0][W-1:0]        samp_t;
    typedef struct { bands_t bands; int t0; int lat; logic to; } frame_t;
    typedef struct { logic [W-1:0] din; int at; } issue_t;

    logic        clk = 1'b0, rst = 1'b1, sample_valid = 1'b0, err_clr = 1'b0, fb_valid = 1'b0;
    samp_t       sample_in = '0;
    logic [N-1:0] stream_en = '0;
    vec_t        fb_dout = '0;
    logic        fb_pcm_valid, frame_valid, busy, overrun, timeout_err;
    logic [W-1:0] fb_din;
    bands_t      band_out;

    int          cyc = 0, n_checks = 0, n_fail = 0, lat_l = 5, pend = 0;
    bit          never = 1'b0;
    logic [W-1:0] pend_din = '0;
    bands_t      ref_bands = '0;
    logic        ref_to = 1'b0;
    frame_t      fq[$];
    issue_t      iq[$];
    frame_t      fr_m;
    issue_t      it_m;

    filterbank_scheduler #(.NUM_STREAMS(N), .NUM_BANDS(B), .DW(W), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .sample_valid(sample_valid), .sample_in(sample_in),
        .stream_en(stream_en), .err_clr(err_clr), .fb_pcm_valid(fb_pcm_valid),
        .fb_din(fb_din), .fb_dout(fb_dout), .fb_valid(fb_valid), .band_out(band_out),
        .frame_valid(frame_valid), .busy(busy), .overrun(overrun), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic vec_t fbm(input logic [W-1:0] x);
        vec_t r;
        for (int b = 0; b < B; b++) r[b] = x ^ W'((b + 1) * 2893);
        return r;
    endfunction

    function automatic vec_t junk();
        vec_t r;
        for (int b = 0; b < B; b++) r[b] = W'($urandom);
        return r;
    endfunction

    // Filterbank model: fb_valid lands lat_l cycles after the fb_pcm_valid cycle
    always @(posedge clk) begin
        fb_valid <= 1'b0;
        fb_dout  <= junk();
        if (rst) begin
            pend <= 0;
        end else begin
            if (pend == 1) begin
                fb_valid <= 1'b1;
                fb_dout  <= fbm(pend_din);
            end
            if (pend > 0) pend <= pend - 1;
            if (fb_pcm_valid && !never) begin
                pend_din <= fb_din;
                if (lat_l == 1) begin
                    fb_valid <= 1'b1;
                    fb_dout  <= fbm(fb_din);
                end else begin
                    pend <= lat_l - 1;
                end
            end
        end
    end

    task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic fail(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: event not expected or never seen", name);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (fb_pcm_valid) begin
                if (iq.size() == 0) fail("pcm_unexpected");
                else begin
                    it_m = iq.pop_front();
                    chk("fb_din", 512'(fb_din), 512'(it_m.din));
                    chk("pcm_cycle", 512'(cyc), 512'(it_m.at));
                end
            end
            if (frame_valid) begin
                if (fq.size() == 0) fail("frame_unexpected");
                else begin
                    fr_m = fq.pop_front();
                    chk("band_out", 512'(band_out), 512'(fr_m.bands));
                    chk("frame_latency", 512'(cyc - fr_m.t0), 512'(fr_m.lat));
                    chk("timeout_err_at_frame", 512'(timeout_err), 512'(fr_m.to));
                end
            end
        end
    end

    // Reference: each enabled stream costs 1+L (or 1+TO when the filterbank is silent)
    task automatic frame(input samp_t s, input logic [N-1:0] en, input bit accept);
        int     k = 0;
        int     per;
        frame_t f;
        issue_t it;
        per = never ? 1 + TO : 1 + lat_l;
        if (accept) begin
            f.t0 = cyc;
            for (int i = 0; i < N; i++) begin
                if (en[i]) begin
                    it.din = s[i];
                    it.at  = cyc + 1 + k * per;
                    iq.push_back(it);
                    if (!never) ref_bands[i] = fbm(s[i]);
                    k++;
                end
            end
            if (never && k > 0) ref_to = 1'b1;
            f.bands = ref_bands;
            f.lat   = 1 + k * per;
            f.to    = ref_to;
            fq.push_back(f);
        end
        sample_in    = s;
        stream_en    = en;
        sample_valid = 1'b1;
        tick();
        sample_valid = 1'b0;
        sample_in    = samp_t'($urandom);
    endtask

    task automatic wait_idle(input int bound);
        int n = 0;
        while ((busy || fq.size() != 0 || iq.size() != 0) && n < bound) begin
            tick();
            n++;
        end
        if (n >= bound) fail("wait_idle_timeout");
    endtask

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "global timeout");
    end

    initial begin
        samp_t s;
        int    bc;

        repeat (3) @(posedge clk);
        #1;
        chk("reset_ctrl", 512'({fb_pcm_valid, frame_valid, busy, overrun, timeout_err}), 512'(0));
        chk("reset_fb_din", 512'(fb_din), 512'(0));
        chk("reset_bands", 512'(band_out), 512'(0));
        rst = 1'b0;
        tick();

        lat_l = 5;
        s = {16'hff00, 16'h1234};
        frame(s, 2'b11, 1'b1);
        wait_idle(200);

        frame(samp_t'($urandom), 2'b10, 1'b1);
        wait_idle(200);

        frame(samp_t'($urandom), 2'b00, 1'b1);
        bc = 0;
        repeat (4) begin
            if (busy) bc++;
            tick();
        end
        chk("busy_cycles_empty", 512'(bc), 512'(1));
        wait_idle(50);

        chk("overrun_pre", 512'(overrun), 512'(0));
        frame(samp_t'($urandom), 2'b11, 1'b1);
        repeat (3) tick();
        frame(samp_t'($urandom), 2'b11, 1'b0);
        chk("overrun_set", 512'(overrun), 512'(1));
        wait_idle(200);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        chk("overrun_clr", 512'(overrun), 512'(0));

        never = 1'b1;
        frame(samp_t'($urandom), 2'b11, 1'b1);
        wait_idle(400);
        never = 1'b0;
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        ref_to = 1'b0;
        chk("timeout_clr", 512'(timeout_err), 512'(0));

        frame(samp_t'($urandom), 2'b11, 1'b1);
        repeat (8) tick();
        rst = 1'b1;
        #1;
        chk("rst_mid_ctrl", 512'({fb_pcm_valid, frame_valid, busy, overrun, timeout_err}), 512'(0));
        chk("rst_mid_fb_din", 512'(fb_din), 512'(0));
        chk("rst_mid_bands", 512'(band_out), 512'(0));
        fq.delete();
        iq.delete();
        ref_bands = '0;
        ref_to = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        repeat (20) tick();
        frame(samp_t'($urandom), 2'b11, 1'b1);
        wait_idle(200);

        for (int r = 0; r < 24; r++) begin
            lat_l = $urandom_range(1, 40);
            frame(samp_t'($urandom), N'($urandom), 1'b1);
            wait_idle(300);
            repeat ($urandom_range(0, 3)) tick();
        end
        chk("final_bands", 512'(band_out), 512'(ref_bands));
        chk("final_flags", 512'({overrun, timeout_err}), 512'({1'b0, ref_to}));

        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
        $finish;
    end
endmodule
